// File: rtl/tree_lookup_ctrl.sv
// Path lookup sequencer over the synchronous tree node RAM.
// Define TREE_LOOKUP_PERF_CNT_EN to add lookup/miss counters.
module tree_lookup_ctrl #(
  parameter int IDENTIFIER_SIZE = 8,
  parameter int NODE_ADDR_SIZE = 8,
  parameter int MAX_NODES_PER_LEVEL = 4,
  parameter int NODE_SIZE =
    IDENTIFIER_SIZE + NODE_ADDR_SIZE * (MAX_NODES_PER_LEVEL + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic id_valid,
  output logic id_ready,
  input  logic [IDENTIFIER_SIZE-1:0] id_data,
  input  logic id_last,
  output logic mem_rd_en,
  output logic [NODE_ADDR_SIZE-1:0] mem_rd_addr,
  input  logic [NODE_SIZE-1:0] mem_rd_data,
  output logic res_valid,
  input  logic res_ready,
  output logic [NODE_ADDR_SIZE-1:0] res_addr,
  output logic res_found
`ifdef TREE_LOOKUP_PERF_CNT_EN
  ,
  output logic [15:0] cnt_lookups,
  output logic [15:0] cnt_misses
`endif
);

  localparam int KW = $clog2(MAX_NODES_PER_LEVEL + 1);
  localparam int KI =
    (MAX_NODES_PER_LEVEL > 1) ? $clog2(MAX_NODES_PER_LEVEL) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_NODE, LATCH, RD_CHILD, CMP, DRAIN, RESP
  } state_e;

  state_e state_q, state_d;
  logic [NODE_ADDR_SIZE-1:0] cur_addr_q, cur_addr_d;
  logic miss_q, miss_d;
  logic [KW-1:0] k_q, k_d;
  logic [IDENTIFIER_SIZE-1:0] id_q, id_d;
  logic last_q, last_d;
  logic [NODE_ADDR_SIZE-1:0] slot_q [MAX_NODES_PER_LEVEL];
  logic [NODE_ADDR_SIZE-1:0] slot_d [MAX_NODES_PER_LEVEL];
  logic [NODE_ADDR_SIZE-1:0] cur_slot;
  logic k_end;

  // k_end guards the slot index, so the truncated index never aliases
  assign k_end = (k_q == KW'(MAX_NODES_PER_LEVEL));
  assign cur_slot = slot_q[k_q[KI-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_addr_q <= '0;
      miss_q <= 1'b0;
      k_q <= '0;
      id_q <= '0;
      last_q <= 1'b0;
      for (int i = 0; i < MAX_NODES_PER_LEVEL; i++)
        slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cur_addr_q <= cur_addr_d;
      miss_q <= miss_d;
      k_q <= k_d;
      id_q <= id_d;
      last_q <= last_d;
      slot_q <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_addr_d = cur_addr_q;
    miss_d = miss_q;
    k_d = k_q;
    id_d = id_q;
    last_d = last_q;
    slot_d = slot_q;
    id_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_rd_addr = '0;
    res_valid = 1'b0;
    res_addr = '0;
    res_found = 1'b0;
    unique case (state_q)
      IDLE: begin
        id_ready = 1'b1;
        if (id_valid) begin
          id_d = id_data;
          last_d = id_last;
          if (id_data == '0 || miss_q) begin
            miss_d = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = RD_NODE;
          end
        end
      end
      RD_NODE: begin
        mem_rd_en = 1'b1;
        mem_rd_addr = cur_addr_q;
        state_d = LATCH;
      end
      LATCH: begin
        for (int i = 0; i < MAX_NODES_PER_LEVEL; i++)
          slot_d[i] = mem_rd_data[IDENTIFIER_SIZE + i*NODE_ADDR_SIZE
                                  +: NODE_ADDR_SIZE];
        k_d = '0;
        state_d = RD_CHILD;
      end
      RD_CHILD: begin
        if (k_end || cur_slot == '0) begin
          miss_d = 1'b1;
          state_d = DRAIN;
        end else begin
          mem_rd_en = 1'b1;
          mem_rd_addr = cur_slot;
          state_d = CMP;
        end
      end
      CMP: begin
        if (mem_rd_data[IDENTIFIER_SIZE-1:0] == id_q) begin
          cur_addr_d = cur_slot;
          state_d = DRAIN;
        end else begin
          k_d = k_q + KW'(1);
          state_d = RD_CHILD;
        end
      end
      DRAIN: state_d = last_q ? RESP : IDLE;
      RESP: begin
        res_valid = 1'b1;
        res_addr = cur_addr_q;
        res_found = !miss_q;
        if (res_ready) begin
          cur_addr_d = '0;
          miss_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TREE_LOOKUP_PERF_CNT_EN
  logic [15:0] cnt_lookups_q, cnt_misses_q;
  logic resp_hs;

  assign resp_hs = (state_q == RESP) && res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lookups_q <= '0;
      cnt_misses_q <= '0;
    end else if (resp_hs) begin
      if (cnt_lookups_q != 16'hFFFF)
        cnt_lookups_q <= cnt_lookups_q + 16'd1;
      if (miss_q && cnt_misses_q != 16'hFFFF)
        cnt_misses_q <= cnt_misses_q + 16'd1;
    end
  end

  assign cnt_lookups = cnt_lookups_q;
  assign cnt_misses = cnt_misses_q;
`endif

endmodule

// File: tb/tb_tree_lookup_ctrl.sv
// Bench for tree_lookup_ctrl: vector table plus scoreboard,
// backpressure and mid-walk reset sequences.
module tb_tree_lookup_ctrl;
  localparam int IW = 8;
  localparam int AW = 8;
  localparam int MN = 4;
  localparam int NW = IW + AW * (MN + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic id_ready;
  logic [IW-1:0] id_data = '0;
  logic id_last = 1'b0;
  logic mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [NW-1:0] mem_rd_data = '0;
  logic res_valid;
  logic res_ready = 1'b1;
  logic [AW-1:0] res_addr;
  logic res_found;
`ifdef TREE_LOOKUP_PERF_CNT_EN
  logic [15:0] cnt_lookups;
  logic [15:0] cnt_misses;
`endif

  tree_lookup_ctrl #(
    .IDENTIFIER_SIZE(IW),
    .NODE_ADDR_SIZE(AW),
    .MAX_NODES_PER_LEVEL(MN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_data(id_data),
    .id_last(id_last),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_addr(res_addr),
    .res_found(res_found)
`ifdef TREE_LOOKUP_PERF_CNT_EN
    ,
    .cnt_lookups(cnt_lookups),
    .cnt_misses(cnt_misses)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NW-1:0] mem [256];
  always @(posedge clk)
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  function automatic logic [NW-1:0] node(
    input logic [7:0] id, input logic [7:0] c0,
    input logic [7:0] c1, input logic [7:0] c2);
    return {8'h00, c2, c1, c0, id};
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint a,
                     input longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask

  typedef struct {
    logic [2:0][7:0] ids;
    int n;
    logic [7:0] addr;
    logic found;
    int lat;
    int gap;
    int reads;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic found;
    int start;
    int lat;
    int reads;
  } exp_t;

  exp_t sbq[$];

  function automatic vec_t mk(
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] c, input int n,
    input logic [7:0] addr, input logic found,
    input int lat, input int gap, input int reads);
    vec_t v;
    v.ids = {c, b, a};
    v.n = n;
    v.addr = addr;
    v.found = found;
    v.lat = lat;
    v.gap = gap;
    v.reads = reads;
    return v;
  endfunction

  // Scoreboard side: pops on every result handshake
  int rd_cnt = 0;
  int t_rv = 0;
  bit prev_rv = 0;
  bit prev_rd = 0;
  int n_done = 0;
  int n_miss = 0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0;
      prev_rv = 0;
      prev_rd = 0;
      n_done = 0;
      n_miss = 0;
    end else begin
      if (mem_rd_en) begin
        chk("rd_spacing", prev_rd, 0);
        rd_cnt++;
      end
      prev_rd = mem_rd_en;
      if (res_valid && !prev_rv) t_rv = cyc;
      prev_rv = res_valid;
      if (res_valid && res_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("res_addr", res_addr, e.addr);
          chk("res_found", res_found, e.found);
          chk("latency", t_rv - e.start, e.lat);
          chk("mem_reads", rd_cnt, e.reads);
        end
        n_done++;
        if (!res_found) n_miss++;
        rd_cnt = 0;
      end
    end
  end

  // Caller enters just after a rising edge
  task automatic send_path(input vec_t v, input bit push,
                           output int t0, output int t1);
    int acc;
    exp_t x;
    t0 = 0;
    t1 = 0;
    for (int i = 0; i < v.n; i++) begin
      id_valid = 1'b1;
      id_data = v.ids[i];
      id_last = (i == v.n - 1);
      acc = -1;
      for (int w = 0; w < 100; w++) begin
        @(negedge clk);
        if (id_ready) begin
          acc = cyc;
          break;
        end
      end
      if (acc < 0) begin
        chk("id_accept_timeout", 1, 0);
        id_valid = 1'b0;
        return;
      end
      if (i == 0) begin
        t0 = acc;
        if (push) begin
          x.addr = v.addr;
          x.found = v.found;
          x.start = acc;
          x.lat = v.lat;
          x.reads = v.reads;
          sbq.push_back(x);
        end
      end
      if (i == 1) t1 = acc;
      @(posedge clk);
      #1;
    end
    id_valid = 1'b0;
    id_last = 1'b0;
    id_data = '0;
  endtask

  task automatic wait_empty();
    for (int w = 0; w < 200; w++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    chk("result_timeout", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, "_id_ready"}, id_ready, 1);
    chk({nm, "_res_valid"}, res_valid, 0);
    chk({nm, "_mem_rd_en"}, mem_rd_en, 0);
    chk({nm, "_res_addr"}, res_addr, 0);
    chk({nm, "_res_found"}, res_found, 0);
  endtask

  vec_t vecs[6];
  vec_t v;
  int t0, t1;
`ifdef TREE_LOOKUP_PERF_CNT_EN
  logic [15:0] cnt0;
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = node(8'h00, 8'd1, 8'd3, 8'd0);
    mem[1] = node(8'h10, 8'd2, 8'd0, 8'd0);
    mem[2] = node(8'h20, 8'd0, 8'd0, 8'd0);
    mem[3] = node(8'h30, 8'd0, 8'd0, 8'd0);

    vecs[0] = mk(8'h10, 8'h20, 8'h00, 2, 8'd2, 1'b1, 12, 6, 4);
    vecs[1] = mk(8'h30, 8'h00, 8'h00, 1, 8'd3, 1'b1, 8, 0, 3);
    vecs[2] = mk(8'h40, 8'h00, 8'h00, 1, 8'd0, 1'b0, 9, 0, 3);
    vecs[3] = mk(8'h10, 8'h99, 8'h20, 3, 8'd1, 1'b0, 15, 6, 4);
    vecs[4] = mk(8'h10, 8'h00, 8'h00, 1, 8'd1, 1'b1, 6, 0, 2);
    vecs[5] = mk(8'h10, 8'h20, 8'h55, 3, 8'd2, 1'b0, 17, 6, 5);

    repeat (2) @(negedge clk);
    chk_idle_outs("in_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outs("post_reset");
`ifdef TREE_LOOKUP_PERF_CNT_EN
    chk("cnt_lookups_reset", cnt_lookups, 0);
    chk("cnt_misses_reset", cnt_misses, 0);
`endif
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      send_path(vecs[i], 1'b1, t0, t1);
      if (vecs[i].n > 1) chk("second_id_gap", t1 - t0, vecs[i].gap);
      wait_empty();
    end
`ifdef TREE_LOOKUP_PERF_CNT_EN
    chk("cnt_lookups", cnt_lookups, n_done);
    chk("cnt_misses", cnt_misses, n_miss);
    cnt0 = cnt_lookups;
`endif

    // Backpressure: hold res_ready low while the result waits
    res_ready = 1'b0;
    v = mk(8'h30, 8'h00, 8'h00, 1, 8'd3, 1'b1, 8, 0, 3);
    send_path(v, 1'b1, t0, t1);
    for (int w = 0; w < 50; w++) begin
      if (res_valid) break;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_addr", res_addr, 3);
      chk("bp_res_found", res_found, 1);
      chk("bp_id_ready", id_ready, 0);
`ifdef TREE_LOOKUP_PERF_CNT_EN
      chk("bp_cnt_hold", cnt_lookups, cnt0);
`endif
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_empty();
`ifdef TREE_LOOKUP_PERF_CNT_EN
    chk("bp_cnt_once", cnt_lookups, cnt0 + 16'd1);
`endif

    // Reset during the slot-0 compare of a walk
    v = mk(8'h40, 8'h00, 8'h00, 1, 8'd0, 1'b0, 0, 0, 0);
    send_path(v, 1'b0, t0, t1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_idle_outs("mid_reset");
`ifdef TREE_LOOKUP_PERF_CNT_EN
    chk("mid_reset_cnt", cnt_lookups, 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outs("after_abort");
    @(posedge clk);
    #1;
    v = mk(8'h10, 8'h00, 8'h00, 1, 8'd1, 1'b1, 6, 0, 2);
    send_path(v, 1'b1, t0, t1);
    wait_empty();
    repeat (5) @(posedge clk);
`ifdef TREE_LOOKUP_PERF_CNT_EN
    chk("cnt_after_reset", cnt_lookups, 1);
`endif
    chk("no_stray_results", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
